// File: rtl/oled_spi_tx.sv
// Serialises a page-organised 128x64 monochrome framebuffer onto an SSD1306-style
// 4-wire link: one invert command, then per page a page command and its data bytes.
module oled_spi_tx #(
  parameter int CLK_DIV = 2,
  parameter int COLS    = 128,
  parameter int PAGES   = 8
) (
  input  logic       oled_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       invert,
  output logic       busy,
  output logic       done,
  output logic [9:0] fb_addr,
  input  logic [7:0] fb_data,
  output logic       oled_sck,
  output logic       oled_dc,
  output logic       oled_mosi,
  output logic       oled_cs_n
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] K_INV  = 2'd0;
  localparam logic [1:0] K_PAGE = 2'd1;
  localparam logic [1:0] K_DATA = 2'd2;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [6:0] COL_LAST  = 7'(COLS - 1);
  localparam logic [2:0] PAGE_LAST = 3'(PAGES - 1);

  logic [1:0] state;
  logic [1:0] kind;
  logic       load2;
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [6:0] col;
  logic [2:0] page;
  logic       inv_lat;
  logic [7:0] shreg;

  logic [1:0] nxt_kind;
  logic [6:0] nxt_col;
  logic [2:0] nxt_page;
  logic       last;
  logic [7:0] cur_byte;

  // Where the sequence goes after the byte currently on the wire.
  always_comb begin
    nxt_kind = kind;
    nxt_col  = col;
    nxt_page = page;
    last     = 1'b0;
    case (kind)
      K_INV: begin
        nxt_kind = K_PAGE;
        nxt_page = 3'd0;
      end
      K_PAGE: begin
        nxt_kind = K_DATA;
        nxt_col  = 7'd0;
      end
      default: begin
        if (col == COL_LAST) begin
          nxt_col = 7'd0;
          if (page == PAGE_LAST) begin
            last = 1'b1;
          end else begin
            nxt_page = page + 3'd1;
            nxt_kind = K_PAGE;
          end
        end else begin
          nxt_col = col + 7'd1;
        end
      end
    endcase
  end

  always_comb begin
    case (kind)
      K_INV:   cur_byte = 8'hA6 | {7'd0, inv_lat};
      K_PAGE:  cur_byte = 8'hB0 | {5'd0, page};
      default: cur_byte = fb_data;
    endcase
  end

  // fb_addr is updated on entry to LOAD so the read data is ready in LOAD cycle 2.
  always_ff @(posedge oled_clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      kind      <= K_INV;
      load2     <= 1'b0;
      div_cnt   <= 8'd0;
      bit_cnt   <= 3'd0;
      col       <= 7'd0;
      page      <= 3'd0;
      inv_lat   <= 1'b0;
      shreg     <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fb_addr   <= 10'd0;
      oled_sck  <= 1'b0;
      oled_dc   <= 1'b0;
      oled_mosi <= 1'b0;
      oled_cs_n <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            inv_lat   <= invert;
            page      <= 3'd0;
            col       <= 7'd0;
            kind      <= K_INV;
            fb_addr   <= 10'd0;
            load2     <= 1'b0;
            busy      <= 1'b1;
            oled_cs_n <= 1'b0;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!load2) begin
            load2 <= 1'b1;
          end else begin
            load2     <= 1'b0;
            shreg     <= cur_byte;
            oled_mosi <= cur_byte[7];
            oled_dc   <= (kind == K_DATA);
            div_cnt   <= 8'd0;
            bit_cnt   <= 3'd0;
            state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt <= 8'd0;
            if (!oled_sck) begin
              oled_sck <= 1'b1;
            end else begin
              oled_sck <= 1'b0;
              if (bit_cnt != 3'd7) begin
                bit_cnt   <= bit_cnt + 3'd1;
                shreg     <= {shreg[6:0], 1'b0};
                oled_mosi <= shreg[6];
              end else begin
                bit_cnt <= 3'd0;
                kind    <= nxt_kind;
                page    <= nxt_page;
                col     <= nxt_col;
                fb_addr <= {nxt_page, nxt_col};
                if (last) begin
                  state     <= S_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  oled_cs_n <= 1'b1;
                  oled_mosi <= 1'b0;
                  oled_dc   <= 1'b0;
                end else begin
                  state <= S_LOAD;
                end
              end
            end
          end
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
